// File: rtl/updown_ctrl_pkg.sv
// updown_ctrl_pkg
//   Shared types and helpers for the shared up/down step counter and its
//   round-robin arbiter.
//   - dir_e   : step direction carried on each requester's dir bit
//   - rr_next : round-robin pointer advance, modulo the requester count
package updown_ctrl_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Next search start after granting requester `ptr` out of `n`.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin search: grants the first asserted
//   request at or after ptr, wrapping modulo NREQ.
// Ports:
//   req    in  NREQ           pending requests
//   ptr    in  $clog2(NREQ)   index where the search starts
//   gnt    out NREQ           one-hot grant, zero when req is zero
//   gnt_id out $clog2(NREQ)   index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt[idx]   = 1'b1;
                gnt_id     = idx;
            end
        end
    end

endmodule

// File: rtl/updown_counter_arbiter.sv
// updown_counter_arbiter
//   One up/down step counter shared by NREQ requesters. A round-robin
//   arbiter accepts at most one unit step per clock; the accepted step is
//   applied to the count on that edge.
// Ports:
//   clock    in   clock, all state on posedge
//   reset    in   synchronous active-high reset
//   clear    in   synchronous clear of the count; blocks arbitration
//   req      in   NREQ   per-requester pending step
//   dir      in   NREQ   per-requester direction (0 up, 1 down)
//   gnt      out  NREQ   one-hot combinational grant
//   value    out  WIDTH  registered count
//   last_id  out  $clog2(NREQ) most recently granted requester, registered
//   sat_err  out  one-cycle pulse after a clamped step
// Configuration:
//   COUNTER_SAT_EN  defined: the count saturates at 0 and 2^WIDTH-1 and
//                   sat_err reports each clamp; undefined: modulo wrap and
//                   sat_err is constant 0.
module updown_counter_arbiter
    import updown_ctrl_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         dir,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        value,
    output logic [$clog2(NREQ)-1:0] last_id,
    output logic                    sat_err
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [WIDTH-1:0] value_d,   value_q;
    logic [IDW-1:0]   ptr_d,     ptr_q;
    logic [IDW-1:0]   last_id_d, last_id_q;
`ifdef COUNTER_SAT_EN
    logic             sat_err_d, sat_err_q;
`endif

    logic [NREQ-1:0]  arb_req;
    logic [IDW-1:0]   gnt_id;
    logic             step_valid;
    dir_e             step_dir;

    // Reset and clear both suppress arbitration so a pending request stays
    // pending rather than being consumed by a cycle that cannot apply it.
    assign arb_req = (reset || clear) ? '0 : req;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req    (arb_req),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign step_valid = |gnt;
    assign step_dir   = dir_e'(dir[gnt_id]);

    always_comb begin
        value_d   = value_q;
        ptr_d     = ptr_q;
        last_id_d = last_id_q;
`ifdef COUNTER_SAT_EN
        sat_err_d = 1'b0;
`endif
        if (clear) begin
            value_d = '0;
        end else if (step_valid) begin
            ptr_d     = IDW'(rr_next(32'(gnt_id), NREQ));
            last_id_d = gnt_id;
            if (step_dir == DIR_UP) begin
`ifdef COUNTER_SAT_EN
                if (value_q == '1) sat_err_d = 1'b1;
                else               value_d   = value_q + 1'b1;
`else
                value_d = value_q + 1'b1;
`endif
            end else begin
`ifdef COUNTER_SAT_EN
                if (value_q == '0) sat_err_d = 1'b1;
                else               value_d   = value_q - 1'b1;
`else
                value_d = value_q - 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q   <= '0;
            ptr_q     <= '0;
            last_id_q <= '0;
`ifdef COUNTER_SAT_EN
            sat_err_q <= 1'b0;
`endif
        end else begin
            value_q   <= value_d;
            ptr_q     <= ptr_d;
            last_id_q <= last_id_d;
`ifdef COUNTER_SAT_EN
            sat_err_q <= sat_err_d;
`endif
        end
    end

    assign value   = value_q;
    assign last_id = last_id_q;
`ifdef COUNTER_SAT_EN
    assign sat_err = sat_err_q;
`else
    assign sat_err = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter_arbiter.sv
module tb_updown_counter_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             clear = 1'b0;
    logic [NREQ-1:0]  req   = '0;
    logic [NREQ-1:0]  dir   = '0;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] value;
    logic [1:0]       last_id;
    logic             sat_err;

    updown_counter_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .req     (req),
        .dir     (dir),
        .gnt     (gnt),
        .value   (value),
        .last_id (last_id),
        .sat_err (sat_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [NREQ-1:0]  req;
        logic             blocked;
        logic [NREQ-1:0]  gnt;
        logic [WIDTH-1:0] value;
        logic [1:0]       last_id;
        logic             sat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state: the count as a plain integer, the round-robin
    // start index, the last granted index and the pending clamp flag.
    int   m_count = 0;
    int   m_ptr   = 0;
    int   m_last  = 0;
    bit   m_sat   = 0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // One clock of stimulus: drive inputs just after the edge, push what the
    // DUT must show during this cycle, then advance the model across the
    // next edge.
    task automatic cycle(input logic r, input logic c, input logic [NREQ-1:0] rq,
                         input logic [NREQ-1:0] d);
        exp_t e;
        int   g;
        @(posedge clock);
        #1;
        reset = r; clear = c; req = rq; dir = d;
        g = (r || c) ? -1 : pick(rq, m_ptr);
        e.req     = rq;
        e.blocked = r || c;
        e.gnt     = (g >= 0) ? NREQ'(1 << g) : '0;
        e.value   = WIDTH'(m_count);
        e.last_id = 2'(m_last);
        e.sat     = m_sat;
        exp_q.push_back(e);

        m_sat = 0;
        if (r) begin
            m_count = 0; m_ptr = 0; m_last = 0;
        end else if (c) begin
            m_count = 0;
        end else if (g >= 0) begin
            m_ptr  = (g + 1) % NREQ;
            m_last = g;
            if (d[g] == 1'b0) begin
`ifdef COUNTER_SAT_EN
                if (m_count == 255) m_sat = 1; else m_count = m_count + 1;
`else
                m_count = (m_count + 1) % 256;
`endif
            end else begin
`ifdef COUNTER_SAT_EN
                if (m_count == 0) m_sat = 1; else m_count = m_count - 1;
`else
                m_count = (m_count + 255) % 256;
`endif
            end
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    int wait_cnt[NREQ];
    initial for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            int   maxw;
            e = exp_q.pop_front();
            check("gnt",     int'(gnt),     int'(e.gnt));
            check("value",   int'(value),   int'(e.value));
            check("last_id", int'(last_id), int'(e.last_id));
            check("sat_err", int'(sat_err), int'(e.sat));

            tests++;
            if (!$onehot0(gnt) || ((gnt & ~e.req) != '0)) begin
                fails++;
                $display("FAIL gnt_onehot: got %b with req %b", gnt, e.req);
            end

            maxw = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!e.req[i] || gnt[i]) wait_cnt[i] = 0;
                else if (!e.blocked)     wait_cnt[i]++;
                if (wait_cnt[i] > maxw) maxw = wait_cnt[i];
            end
            tests++;
            if (maxw > NREQ - 1) begin
                fails++;
                $display("FAIL fairness: waited %0d cycles, bound %0d", maxw, NREQ - 1);
            end
        end
    end

    initial begin
        int guard;
        // 1. reset, then idle
        cycle(1, 0, '0, '0);
        cycle(1, 0, '0, '0);
        repeat (5) cycle(0, 0, '0, '0);

        // 2. all request up for 8 cycles
        repeat (8) cycle(0, 0, 4'b1111, 4'b0000);

        // 3. down to 5, then requesters 0 (up) and 2 (down) alternate
        repeat (3) cycle(0, 0, 4'b0001, 4'b0001);
        repeat (4) cycle(0, 0, 4'b0101, 4'b0100);

        // 4. climb to 255, step up past it, descend to 0, step down past it
        guard = 0;
        while (m_count != 255 && guard < 300) begin
            cycle(0, 0, NREQ'($urandom_range(1, 15)), '0);
            guard++;
        end
        check("reach_255", m_count, 255);
        cycle(0, 0, 4'b1000, 4'b0000);
        cycle(0, 0, '0, '0);
        guard = 0;
        while (m_count != 0 && guard < 300) begin
            cycle(0, 0, NREQ'($urandom_range(1, 15)), 4'b1111);
            guard++;
        end
        check("reach_0", m_count, 0);
        cycle(0, 0, 4'b0100, 4'b1111);
        cycle(0, 0, '0, '0);

        // 5. clear with a pending request, request granted the cycle after
        repeat (2) cycle(0, 0, 4'b0001, 4'b0000);
        cycle(0, 1, 4'b0010, 4'b0000);
        cycle(0, 0, 4'b0010, 4'b0000);
        cycle(0, 0, '0, '0);

        // 6. reset in the middle of a burst at value 3
        cycle(0, 1, '0, '0);
        repeat (3) cycle(0, 0, 4'b0100, 4'b0000);
        cycle(0, 0, 4'b1111, 4'b0000);
        cycle(1, 0, 4'b1111, 4'b0000);
        repeat (5) cycle(0, 0, 4'b1111, 4'b0000);

        // Randomised traffic with occasional clear and reset
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 15) == 0),
                  NREQ'($urandom), NREQ'($urandom));
        end
        cycle(0, 0, '0, '0);

        @(negedge clock);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
